// File: rtl/clk_tick_gen.sv
// 1 s count-enable prescaler plus synchronised, debounced push-button increment pulse.
// Define AUTO_REPEAT_EN to emit repeated increments while the button stays held.
module clk_tick_gen #(
    parameter int DIV_SEC = 50_000_000,
    parameter int DEB_CYC = 500_000,
    parameter int RPT_DLY = 25_000_000,
    parameter int RPT_PER = 10_000_000
) (
    input  logic CLK,
    input  logic RST,
    input  logic CLR,
    input  logic SET_MODE,
    input  logic BTN_IN,
    output logic SEC_EN,
    output logic INC,
    output logic BTN_LVL
);

    localparam int PC_W = (DIV_SEC > 2) ? $clog2(DIV_SEC) : 1;
    localparam int DC_W = (DEB_CYC > 1) ? $clog2(DEB_CYC) : 1;
    localparam logic [PC_W-1:0] PC_LAST = PC_W'(DIV_SEC - 1);
    localparam logic [DC_W-1:0] DC_LAST = DC_W'(DEB_CYC - 1);
    // Illegal parameter sets never produce increments.
    localparam bit PARAMS_OK = (DIV_SEC >= 2) && (DEB_CYC >= 1) && (RPT_DLY >= 1) && (RPT_PER >= 1);

    typedef enum logic [1:0] {IDLE, PRESS_CHK, HELD, REL_CHK} state_t;

    logic [PC_W-1:0] pc_q, pc_d;
    logic            sec_en_q, sec_en_d;
    logic            s1_q, s2_q;
    state_t          state_q, state_d;
    logic [DC_W-1:0] dc_q, dc_d;
    logic            lvl_q, lvl_d;
    logic            inc_q, inc_d;
    logic            press_evt;
    logic            press_any;

    always_comb begin
        pc_d     = pc_q + PC_W'(1);
        sec_en_d = 1'b0;
        if (CLR || SET_MODE) begin
            pc_d = '0;
        end else if (pc_q == PC_LAST) begin
            pc_d     = '0;
            sec_en_d = 1'b1;
        end
    end

    always_comb begin
        state_d   = state_q;
        dc_d      = dc_q;
        lvl_d     = lvl_q;
        press_evt = 1'b0;
        case (state_q)
            IDLE: begin
                if (s2_q) begin
                    state_d = PRESS_CHK;
                    dc_d    = '0;
                end
            end
            PRESS_CHK: begin
                if (!s2_q) begin
                    state_d = IDLE;
                    dc_d    = '0;
                end else if (dc_q == DC_LAST) begin
                    state_d   = HELD;
                    dc_d      = '0;
                    lvl_d     = 1'b1;
                    press_evt = 1'b1;
                end else begin
                    dc_d = dc_q + DC_W'(1);
                end
            end
            HELD: begin
                if (!s2_q) begin
                    state_d = REL_CHK;
                    dc_d    = '0;
                end
            end
            REL_CHK: begin
                // A bounce back to high resumes the hold without a new press event.
                if (s2_q) begin
                    state_d = HELD;
                    dc_d    = '0;
                end else if (dc_q == DC_LAST) begin
                    state_d = IDLE;
                    dc_d    = '0;
                    lvl_d   = 1'b0;
                end else begin
                    dc_d = dc_q + DC_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
                dc_d    = '0;
            end
        endcase
    end

`ifdef AUTO_REPEAT_EN
    localparam int RPT_MAX = (RPT_DLY > RPT_PER) ? RPT_DLY : RPT_PER;
    localparam int RC_W    = (RPT_MAX > 1) ? $clog2(RPT_MAX) : 1;
    localparam logic [RC_W-1:0] RC_DLY_LAST = RC_W'(RPT_DLY - 1);
    localparam logic [RC_W-1:0] RC_PER_LAST = RC_W'(RPT_PER - 1);

    logic [RC_W-1:0] rc_q, rc_d;
    logic            rpt_armed_q, rpt_armed_d;
    logic            rpt_evt;

    // First repeat waits RPT_DLY after HELD entry, later ones RPT_PER apart.
    always_comb begin
        rc_d        = '0;
        rpt_armed_d = 1'b0;
        rpt_evt     = 1'b0;
        if (state_q == HELD && s2_q) begin
            rpt_armed_d = rpt_armed_q;
            if (rc_q == (rpt_armed_q ? RC_PER_LAST : RC_DLY_LAST)) begin
                rpt_evt     = 1'b1;
                rpt_armed_d = 1'b1;
            end else begin
                rc_d = rc_q + RC_W'(1);
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            rc_q        <= '0;
            rpt_armed_q <= 1'b0;
        end else begin
            rc_q        <= rc_d;
            rpt_armed_q <= rpt_armed_d;
        end
    end

    assign press_any = PARAMS_OK && (press_evt || rpt_evt);
`else
    assign press_any = PARAMS_OK && press_evt;
`endif

    assign inc_d = press_any && SET_MODE;

    always_ff @(posedge CLK) begin
        if (RST) begin
            pc_q     <= '0;
            sec_en_q <= 1'b0;
            s1_q     <= 1'b0;
            s2_q     <= 1'b0;
            state_q  <= IDLE;
            dc_q     <= '0;
            lvl_q    <= 1'b0;
            inc_q    <= 1'b0;
        end else begin
            pc_q     <= pc_d;
            sec_en_q <= sec_en_d;
            s1_q     <= BTN_IN;
            s2_q     <= s1_q;
            state_q  <= state_d;
            dc_q     <= dc_d;
            lvl_q    <= lvl_d;
            inc_q    <= inc_d;
        end
    end

    assign SEC_EN  = sec_en_q;
    assign INC     = inc_q;
    assign BTN_LVL = lvl_q;

endmodule

// File: tb/tb_clk_tick_gen.sv
// Bench for clk_tick_gen: fixed vector table, corner-case sequences and randomized
// stimulus against a cycle-count reference model. Honours AUTO_REPEAT_EN.
module tb_clk_tick_gen;

    localparam int DIV_SEC = 10;
    localparam int DEB_CYC = 4;
    localparam int RPT_DLY = 8;
    localparam int RPT_PER = 3;

    logic CLK = 1'b0;
    logic RST = 1'b1;
    logic CLR = 1'b0;
    logic SET_MODE = 1'b0;
    logic BTN_IN = 1'b0;
    logic SEC_EN, INC, BTN_LVL;

    int n_chk = 0;
    int n_fail = 0;
    int cyc = 0;

    clk_tick_gen #(
        .DIV_SEC(DIV_SEC), .DEB_CYC(DEB_CYC), .RPT_DLY(RPT_DLY), .RPT_PER(RPT_PER)
    ) dut (
        .CLK(CLK), .RST(RST), .CLR(CLR), .SET_MODE(SET_MODE), .BTN_IN(BTN_IN),
        .SEC_EN(SEC_EN), .INC(INC), .BTN_LVL(BTN_LVL)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        bit rst, clr, mode, btn;
        bit sec, inc, lvl;
    } vec_t;
    vec_t tbl[20];

    // Reference model: button history, stability run lengths, hold age and
    // cycles since the last prescaler clear.
    bit m_h1, m_h2, m_lvl, m_sec, m_inc;
    int m_run, m_age, m_since;

    task automatic model_edge(input bit rst, input bit clr, input bit mode, input bit btn);
        bit s2, press;
        if (rst) begin
            m_h1 = 0; m_h2 = 0; m_lvl = 0; m_sec = 0; m_inc = 0;
            m_run = 0; m_age = 0; m_since = 0;
            return;
        end
        s2 = m_h2;
        m_h2 = m_h1;
        m_h1 = btn;
        press = 0;
        if (!m_lvl) begin
            m_run = s2 ? m_run + 1 : 0;
            if (m_run == DEB_CYC + 1) begin
                m_lvl = 1; m_run = 0; m_age = 0; press = 1;
            end
        end else if (!s2) begin
            m_run++;
            m_age = 0;
            if (m_run == DEB_CYC + 1) begin
                m_lvl = 0; m_run = 0;
            end
        end else if (m_run > 0) begin
            m_run = 0;
            m_age = 0;
        end else begin
            m_age++;
`ifdef AUTO_REPEAT_EN
            if (m_age >= RPT_DLY && (m_age - RPT_DLY) % RPT_PER == 0) press = 1;
`endif
        end
        m_inc = press && mode;
        if (clr || mode) begin
            m_since = 0;
            m_sec = 0;
        end else begin
            m_since++;
            m_sec = (m_since % DIV_SEC == 0);
        end
    endtask

    task automatic check(input string name, input logic act, input logic exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0b, expected %0b (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic check_int(input string name, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic step(input bit rst, input bit clr, input bit mode, input bit btn, input bit chk);
        RST = rst; CLR = clr; SET_MODE = mode; BTN_IN = btn;
        @(posedge CLK);
        model_edge(rst, clr, mode, btn);
        cyc++;
        #1;
        if (chk) begin
            check("sec_en", SEC_EN, m_sec);
            check("inc", INC, m_inc);
            check("btn_lvl", BTN_LVL, m_lvl);
            check("sec_and_inc", SEC_EN & INC, 1'b0);
        end
    endtask

    initial begin
        int t0, first, cnt, hold;
        int got[$];
        int exp_q[$];
        bit lvl_r, mode_r;
        int seg_left;

        // rst clr mode btn | sec inc lvl
        tbl[0]  = '{1, 0, 0, 0, 0, 0, 0};
        tbl[1]  = '{0, 0, 0, 0, 0, 0, 0};
        tbl[2]  = '{0, 0, 0, 0, 0, 0, 0};
        tbl[3]  = '{0, 0, 0, 0, 0, 0, 0};
        tbl[4]  = '{0, 0, 0, 0, 0, 0, 0};
        tbl[5]  = '{0, 0, 0, 0, 0, 0, 0};
        tbl[6]  = '{0, 0, 0, 0, 0, 0, 0};
        tbl[7]  = '{0, 0, 0, 0, 0, 0, 0};
        tbl[8]  = '{0, 0, 0, 0, 0, 0, 0};
        tbl[9]  = '{0, 0, 0, 0, 0, 0, 0};
        tbl[10] = '{0, 0, 0, 0, 1, 0, 0};
        tbl[11] = '{0, 0, 0, 0, 0, 0, 0};
        tbl[12] = '{0, 0, 1, 1, 0, 0, 0};
        tbl[13] = '{0, 0, 1, 1, 0, 0, 0};
        tbl[14] = '{0, 0, 1, 1, 0, 0, 0};
        tbl[15] = '{0, 0, 1, 1, 0, 0, 0};
        tbl[16] = '{0, 0, 1, 1, 0, 0, 0};
        tbl[17] = '{0, 0, 1, 1, 0, 0, 0};
        tbl[18] = '{0, 0, 1, 1, 0, 1, 1};
        tbl[19] = '{0, 0, 1, 1, 0, 0, 1};

        for (int i = 0; i < 20; i++) begin
            step(tbl[i].rst, tbl[i].clr, tbl[i].mode, tbl[i].btn, 1'b0);
            check($sformatf("tbl%0d_sec", i), SEC_EN, tbl[i].sec);
            check($sformatf("tbl%0d_inc", i), INC, tbl[i].inc);
            check($sformatf("tbl%0d_lvl", i), BTN_LVL, tbl[i].lvl);
        end

        // Glitch shorter than the debounce window, then a press with release bounce.
        step(1, 0, 1, 0, 1);
        cnt = 0;
        for (int i = 0; i < 13; i++) begin
            step(0, 0, 1, i < 3, 1);
            if (INC) cnt++;
        end
        check_int("glitch_inc_count", cnt, 0);
        check("glitch_lvl", BTN_LVL, 1'b0);
        for (int i = 0; i < 27; i++) begin
            step(0, 0, 1, (i < 12) || (i == 14), 1);
            if (INC) cnt++;
        end
        check_int("bounce_inc_count", cnt, 1);
        check("bounce_final_lvl", BTN_LVL, 1'b0);

        // Long hold: one INC at acceptance, plus auto-repeats when enabled.
        hold = 30;
        step(1, 0, 1, 0, 1);
        t0 = cyc + 1;
        for (int i = 0; i < 45; i++) begin
            step(0, 0, 1, i < hold, 1);
            if (INC) got.push_back(cyc - t0);
        end
        exp_q.push_back(DEB_CYC + 2);
`ifdef AUTO_REPEAT_EN
        for (int t = DEB_CYC + 2 + RPT_DLY; t <= hold + 1; t += RPT_PER) exp_q.push_back(t);
`endif
        check_int("hold_inc_count", got.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < got.size(); i++)
            check_int($sformatf("hold_inc%0d_time", i), got[i], exp_q[i]);

        // CLR while the prescaler sits at 6 restarts the full period.
        step(1, 0, 0, 0, 1);
        for (int i = 0; i < 6; i++) step(0, 0, 0, 0, 1);
        step(0, 1, 0, 0, 1);
        first = -1;
        for (int n = 1; n <= 30 && first < 0; n++) begin
            step(0, 0, 0, 0, 1);
            if (SEC_EN) first = n;
        end
        check_int("clr_to_sec_en", first, DIV_SEC);

        // RST in the middle of press qualification, button held through release.
        for (int i = 0; i < 4; i++) step(0, 0, 1, 1, 1);
        step(1, 0, 1, 1, 1);
        check("rst_sec_en", SEC_EN, 1'b0);
        check("rst_inc", INC, 1'b0);
        check("rst_lvl", BTN_LVL, 1'b0);
        first = -1;
        for (int n = 0; n < 20; n++) begin
            step(0, 0, 1, 1, 1);
            if (INC && first < 0) first = n;
        end
        check_int("held_through_rst_inc", first, DEB_CYC + 2);

        // Randomized stimulus against the model.
        step(1, 0, 0, 0, 1);
        lvl_r = 0; mode_r = 0; seg_left = 0;
        for (int i = 0; i < 2000; i++) begin
            if (seg_left == 0) begin
                lvl_r = ~lvl_r;
                seg_left = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 3))
                                                       : int'($urandom_range(4, 40));
            end
            if ($urandom_range(0, 59) == 0) mode_r = ~mode_r;
            step($urandom_range(0, 399) == 0, $urandom_range(0, 49) == 0, mode_r, lvl_r, 1);
            seg_left--;
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
